// File: rtl/adder_issue_ctrl_pkg.sv
// Shared types and constants for the adder_issue_ctrl block: FSM state
// encoding, settle-cycle limits and the settle-counter load helper.
package adder_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int SETTLE_CYCLES_MAX = 15;
  localparam int CNT_W             = 4;

  // Out-of-range settle values are clamped so the 4-bit counter never wraps.
  function automatic logic [CNT_W-1:0] settle_load(input int cycles);
    int c;
    c = (cycles < 1) ? 1 : ((cycles > SETTLE_CYCLES_MAX) ? SETTLE_CYCLES_MAX : cycles);
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/adder_issue_ctrl_ripple_carry.sv
// Team ripple-carry adder: purely combinational WIDTH-bit sum with carry-in
// and carry-out; timing is absorbed by the caller's settle window.
module ripple_carry #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic c;

  always_comb begin
    c     = carry_i;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    carry_o = c;
  end

endmodule

// File: rtl/adder_issue_ctrl.sv
// Valid/ready wrapper around a ripple-carry adder: latches operands, waits
// SETTLE_CYCLES edges, then presents a held result. Optional Zero_o/Overflow_o
// flags are built when ADDER_ISSUE_CTRL_FLAGS_EN is defined.
module adder_issue_ctrl
  import adder_issue_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             Clk_i,
  input  logic             Rst_ni,
  input  logic [WIDTH-1:0] Number1_i,
  input  logic [WIDTH-1:0] Number2_i,
  input  logic             Carry_i,
  input  logic             Valid_i,
  output logic             Ready_o,
  output logic [WIDTH-1:0] Result_o,
  output logic             Carry_o,
  output logic             Valid_o,
  input  logic             Ready_i,
  output logic             Busy_o
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
  ,
  output logic             Zero_o,
  output logic             Overflow_o
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_c_q, op_c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum;
  logic             sum_carry;
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  // The adder only ever sees the latched operands, never the live inputs.
  ripple_carry #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a_i     (op_a_q),
    .b_i     (op_b_q),
    .carry_i (op_c_q),
    .sum_o   (sum),
    .carry_o (sum_carry)
  );

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves one unassigned, which would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_c_d   = op_c_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (Valid_i) begin
          op_a_d  = Number1_i;
          op_b_d  = Number2_i;
          op_c_d  = Carry_i;
          cnt_d   = settle_load(SETTLE_CYCLES);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          result_d = sum;
          carry_d  = sum_carry;
          valid_d  = 1'b1;
          state_d  = DONE;
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
          zero_d   = (sum == '0);
          ovf_d    = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum[WIDTH-1] != op_a_q[WIDTH-1]);
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (Ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clk_i or negedge Rst_ni) begin
    if (!Rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_c_q   <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_c_q   <= op_c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign Ready_o  = (state_q == IDLE);
  assign Busy_o   = (state_q != IDLE);
  assign Result_o = result_q;
  assign Carry_o  = carry_q;
  assign Valid_o  = valid_q;
`ifdef ADDER_ISSUE_CTRL_FLAGS_EN
  assign Zero_o     = zero_q;
  assign Overflow_o = ovf_q;
`endif

endmodule
